// File: rtl/apb_rf_pkg.sv
// Shared types, error-cause codes and width helpers for the APB register-file completer.
package apb_rf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_DECODE = 2'd1;
   localparam logic [1:0] ERR_ALIGN  = 2'd2;
   localparam logic [1:0] ERR_BUSY   = 2'd3;

   // Number of byte strobes for a given data width.
   function automatic int unsigned calc_sw(input int unsigned bus_width);
      return bus_width / 8;
   endfunction

   // Target-index width; a single target still needs one bit.
   function automatic int unsigned calc_tw(input int unsigned ntargets);
      return (ntargets > 1) ? $clog2(ntargets) : 1;
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode: region select, offset, error and no-op classification.
module apb_addr_decode
   import apb_rf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned NTARGETS   = 4,
   parameter int unsigned REGION_AW  = 12,
   parameter int unsigned SW         = 4,
   parameter int unsigned TW         = 2
) (
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  pwrite,
   input  logic [SW-1:0]         pstrb,
   input  logic                  busy,
   output logic [TW-1:0]         tgt,
   output logic [REGION_AW-1:0]  offset,
   output logic                  err,
   output logic                  nop
);

   localparam int unsigned HI = REGION_AW + TW;

   logic [1:0] cause;

   // Classify the access; decode faults take priority over alignment and busy rejection.
   always_comb begin
      tgt    = paddr[REGION_AW +: TW];
      offset = paddr[REGION_AW-1:0];
      cause  = ERR_NONE;
      if (((paddr >> HI) != '0) || (32'(tgt) >= NTARGETS)) begin
         cause = ERR_DECODE;
      end else if ((paddr & ADDR_WIDTH'(SW - 1)) != '0) begin
         cause = ERR_ALIGN;
      end else if (pwrite && busy && (tgt != '0)) begin
         cause = ERR_BUSY;
      end
      err = (cause != ERR_NONE);
      nop = !err && pwrite && (pstrb == '0);
   end

endmodule

// File: rtl/apb_rf_slave.sv
// APB4 completer bridging host accesses to single-beat req/ack register-file targets.
module apb_rf_slave
   import apb_rf_pkg::*;
#(
   parameter int unsigned  BUS_WIDTH   = 32,
   parameter int unsigned  ADDR_WIDTH  = 16,
   parameter int unsigned  NTARGETS    = 4,
   parameter int unsigned  REGION_AW   = 12,
   parameter int unsigned  TIMEOUT_CYC = 16,
   parameter int unsigned  ERR_CNT_W   = 8,
   localparam int unsigned SW          = calc_sw(BUS_WIDTH),
   localparam int unsigned TW          = calc_tw(NTARGETS)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [SW-1:0]         pstrb_i,
   input  logic [BUS_WIDTH-1:0]  pwdata_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   output logic                  pready_o,
   output logic                  pslverr_o,
   output logic [BUS_WIDTH-1:0]  prdata_o,
   input  logic                  busy_i,
   output logic                  rf_req_o,
   output logic                  rf_we_o,
   output logic [TW-1:0]         rf_tgt_o,
   output logic [REGION_AW-1:0]  rf_addr_o,
   output logic [SW-1:0]         rf_be_o,
   output logic [BUS_WIDTH-1:0]  rf_wdata_o,
   input  logic                  rf_ack_i,
   input  logic [BUS_WIDTH-1:0]  rf_rdata_i,
   input  logic                  rf_err_i,
   output logic [ERR_CNT_W-1:0]  err_cnt_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   state_e                state, state_nxt;
   logic [CW-1:0]         tmo_cnt, tmo_cnt_nxt;
   logic                  drop, drop_nxt, drop_now;
   logic                  pready_nxt, pslverr_nxt, rf_req_nxt, rf_we_nxt;
   logic [BUS_WIDTH-1:0]  prdata_nxt, rf_wdata_nxt;
   logic [TW-1:0]         rf_tgt_nxt;
   logic [REGION_AW-1:0]  rf_addr_nxt;
   logic [SW-1:0]         rf_be_nxt;
   logic [ERR_CNT_W-1:0]  err_cnt_nxt;

   logic [TW-1:0]         dec_tgt;
   logic [REGION_AW-1:0]  dec_offset;
   logic                  dec_err, dec_nop;

   apb_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NTARGETS   (NTARGETS),
      .REGION_AW  (REGION_AW),
      .SW         (SW),
      .TW         (TW)
   ) u_decode (
      .paddr  (paddr_i),
      .pwrite (pwrite_i),
      .pstrb  (pstrb_i),
      .busy   (busy_i),
      .tgt    (dec_tgt),
      .offset (dec_offset),
      .err    (dec_err),
      .nop    (dec_nop)
   );

   // State register and registered outputs; synchronous reset abandons any transfer.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state      <= ST_IDLE;
         tmo_cnt    <= '0;
         drop       <= 1'b0;
         pready_o   <= 1'b0;
         pslverr_o  <= 1'b0;
         prdata_o   <= '0;
         rf_req_o   <= 1'b0;
         rf_we_o    <= 1'b0;
         rf_tgt_o   <= '0;
         rf_addr_o  <= '0;
         rf_be_o    <= '0;
         rf_wdata_o <= '0;
         err_cnt_o  <= '0;
      end else begin
         state      <= state_nxt;
         tmo_cnt    <= tmo_cnt_nxt;
         drop       <= drop_nxt;
         pready_o   <= pready_nxt;
         pslverr_o  <= pslverr_nxt;
         prdata_o   <= prdata_nxt;
         rf_req_o   <= rf_req_nxt;
         rf_we_o    <= rf_we_nxt;
         rf_tgt_o   <= rf_tgt_nxt;
         rf_addr_o  <= rf_addr_nxt;
         rf_be_o    <= rf_be_nxt;
         rf_wdata_o <= rf_wdata_nxt;
         err_cnt_o  <= err_cnt_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt    = state;
      tmo_cnt_nxt  = tmo_cnt;
      drop_nxt     = drop;
      drop_now     = drop | ~psel_i;
      pready_nxt   = 1'b0;
      pslverr_nxt  = 1'b0;
      prdata_nxt   = '0;
      rf_req_nxt   = 1'b0;
      rf_we_nxt    = rf_we_o;
      rf_tgt_nxt   = rf_tgt_o;
      rf_addr_nxt  = rf_addr_o;
      rf_be_nxt    = rf_be_o;
      rf_wdata_nxt = rf_wdata_o;
      err_cnt_nxt  = err_cnt_o;

      unique case (state)
         ST_IDLE: begin
            if (psel_i && !penable_i) begin
               rf_we_nxt    = pwrite_i;
               rf_tgt_nxt   = dec_tgt;
               rf_addr_nxt  = dec_offset;
               rf_be_nxt    = pwrite_i ? pstrb_i : '1;
               rf_wdata_nxt = pwdata_i;
               tmo_cnt_nxt  = '0;
               drop_nxt     = 1'b0;
               if (dec_err) begin
                  state_nxt   = ST_RESP;
                  pready_nxt  = 1'b1;
                  pslverr_nxt = 1'b1;
               end else if (dec_nop) begin
                  state_nxt  = ST_RESP;
                  pready_nxt = 1'b1;
               end else begin
                  state_nxt  = ST_REQ;
                  rf_req_nxt = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (rf_ack_i) begin
               if (drop_now) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt   = ST_RESP;
                  pready_nxt  = 1'b1;
                  pslverr_nxt = rf_err_i;
                  if (!rf_we_o && !rf_err_i) begin
                     prdata_nxt = rf_rdata_i;
                  end
               end
            end else if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
               if (drop_now) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt   = ST_RESP;
                  pready_nxt  = 1'b1;
                  pslverr_nxt = 1'b1;
               end
            end else begin
               rf_req_nxt  = 1'b1;
               tmo_cnt_nxt = tmo_cnt + CW'(1);
               drop_nxt    = drop_now;
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (pslverr_nxt && (err_cnt_o != '1)) begin
         err_cnt_nxt = err_cnt_o + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_apb_rf_slave.sv
// Self-checking bench for apb_rf_slave: directed, random, back-to-back, abandon and reset scenarios.
module tb_apb_rf_slave;

   typedef struct packed {
      logic        idle_rdy;
      logic        got;
      logic [7:0]  ws;
      logic [7:0]  reqc;
      logic        err;
      logic [31:0] rdata;
      logic [1:0]  tgt;
      logic [11:0] off;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wd;
      logic [7:0]  ecnt;
   } res_t;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [7:0]  ack;
      logic        terr;
      logic        bsy;
   } vec_t;

   logic        clk, rst_n;
   logic        psel, penable, pwrite, busy;
   logic [3:0]  pstrb;
   logic [31:0] pwdata, prdata;
   logic [15:0] paddr;
   logic        pready, pslverr;
   logic        rf_req, rf_we, rf_ack, rf_err;
   logic [1:0]  rf_tgt;
   logic [11:0] rf_addr;
   logic [3:0]  rf_be;
   logic [31:0] rf_wdata, rf_rdata;
   logic [7:0]  err_cnt;

   logic [31:0] tgt_mem [4096];
   logic [31:0] ref_mem [4096];
   int          ref_ecnt;
   int          checks;
   int          errors;

   apb_rf_slave dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .psel_i     (psel),
      .penable_i  (penable),
      .pwrite_i   (pwrite),
      .pstrb_i    (pstrb),
      .pwdata_i   (pwdata),
      .paddr_i    (paddr),
      .pready_o   (pready),
      .pslverr_o  (pslverr),
      .prdata_o   (prdata),
      .busy_i     (busy),
      .rf_req_o   (rf_req),
      .rf_we_o    (rf_we),
      .rf_tgt_o   (rf_tgt),
      .rf_addr_o  (rf_addr),
      .rf_be_o    (rf_be),
      .rf_wdata_o (rf_wdata),
      .rf_ack_i   (rf_ack),
      .rf_rdata_i (rf_rdata),
      .rf_err_i   (rf_err),
      .err_cnt_o  (err_cnt)
   );

   always #5 clk = ~clk;

   // Reference: outcome of one APB access from the address map and target behaviour.
   task automatic model_xfer(input vec_t v, output res_t e);
      int  idx, off, wi;
      logic derr;
      e    = '0;
      idx  = int'(v.addr) / 4096;
      off  = int'(v.addr) % 4096;
      derr = (idx >= 4) || ((off % 4) != 0) || (v.wr && v.bsy && idx != 0);
      e.got = 1'b1;
      if (derr) begin
         e.err = 1'b1;
      end else if (!(v.wr && v.strb == 4'h0)) begin
         e.tgt = 2'(idx);
         e.off = 12'(off);
         e.be  = v.wr ? v.strb : 4'hF;
         e.we  = v.wr;
         if (v.wr) e.wd = v.wdata;
         if (v.ack == 8'd0) begin
            e.ws = 8'd16; e.reqc = 8'd16; e.err = 1'b1;
         end else begin
            e.ws = v.ack; e.reqc = v.ack; e.err = v.terr;
            wi = idx * 1024 + off / 4;
            if (!v.terr) begin
               if (v.wr) begin
                  for (int b = 0; b < 4; b++)
                     if (v.strb[b]) ref_mem[wi][8*b +: 8] = v.wdata[8*b +: 8];
               end else begin
                  e.rdata = ref_mem[wi];
               end
            end
         end
      end
      if (e.err && ref_ecnt != 255) ref_ecnt++;
      e.ecnt = 8'(ref_ecnt);
   endtask

   // Drive one APB transfer while acting as a memory-backed target; returns what was observed.
   task automatic apb_xfer(input vec_t v, output res_t o);
      int reqc;
      logic [11:0] wi;
      o    = '0;
      reqc = 0;
      @(negedge clk);
      o.idle_rdy = pready;
      psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
      pstrb = v.strb; pwdata = v.wdata; busy = v.bsy;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         penable  = 1'b1;
         rf_ack   = 1'b0;
         rf_err   = 1'b0;
         rf_rdata = $urandom;
         if (rf_req === 1'b1) begin
            reqc++;
            o.tgt = rf_tgt; o.off = rf_addr; o.be = rf_be; o.we = rf_we;
            if (rf_we) o.wd = rf_wdata;
            if (reqc == int'(v.ack)) begin
               rf_ack = 1'b1;
               rf_err = v.terr;
               wi     = {rf_tgt, rf_addr[11:2]};
               if (!v.terr) begin
                  if (rf_we) begin
                     for (int b = 0; b < 4; b++)
                        if (rf_be[b]) tgt_mem[wi][8*b +: 8] = rf_wdata[8*b +: 8];
                  end else begin
                     rf_rdata = tgt_mem[wi];
                  end
               end
            end
         end
         if (pready === 1'b1) begin
            o.got = 1'b1; o.err = pslverr; o.rdata = prdata; o.ecnt = err_cnt;
            break;
         end
         o.ws = o.ws + 8'd1;
      end
      o.reqc = 8'(reqc);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         psel = 1'b0; penable = 1'b0; busy = 1'b0;
      end
   endtask

   task automatic gen(output vec_t v);
      int idx, off;
      idx = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 15);
      off = $urandom_range(0, 1023) * 4;
      if ($urandom_range(0, 9) == 0) off += $urandom_range(1, 3);
      v.addr  = 16'(idx * 4096 + off);
      v.wr    = 1'($urandom_range(0, 1));
      v.strb  = 4'($urandom_range(0, 15));
      v.wdata = $urandom;
      v.ack   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      v.terr  = ($urandom_range(0, 7) == 0);
      v.bsy   = ($urandom_range(0, 4) == 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({pready, pslverr, rf_req, rf_we} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 0000", {pready, pslverr, rf_req, rf_we});
      end
      checks++;
      if ({prdata, rf_tgt, rf_addr, rf_be, rf_wdata, err_cnt} !== '0) begin
         errors++; $display("FAIL reset_bus: prdata=%h rf_wdata=%h err_cnt=%0d expected all 0", prdata, rf_wdata, err_cnt);
      end
      rst_n = 1'b1;
      ref_ecnt = 0;
      idle(1);
   endtask

   task automatic test_directed();
      vec_t v [$];
      res_t o, e;
      tgt_mem[12'h004] = 32'h12345678;
      ref_mem[4]       = 32'h12345678;
      v.push_back('{1'b1, 16'h1004, 4'hF, 32'hDEADBEEF, 8'd1, 1'b0, 1'b0});
      v.push_back('{1'b0, 16'h0010, 4'h0, 32'h0,        8'd3, 1'b0, 1'b0});
      v.push_back('{1'b0, 16'h4000, 4'h0, 32'h0,        8'd1, 1'b0, 1'b0});
      v.push_back('{1'b0, 16'h0002, 4'h0, 32'h0,        8'd1, 1'b0, 1'b0});
      v.push_back('{1'b1, 16'h2000, 4'hF, 32'hA5A5A5A5, 8'd1, 1'b0, 1'b1});
      v.push_back('{1'b1, 16'h0000, 4'hF, 32'hCAFEF00D, 8'd1, 1'b0, 1'b1});
      v.push_back('{1'b0, 16'h3000, 4'h0, 32'h0,        8'd0, 1'b0, 1'b0});
      v.push_back('{1'b1, 16'h1008, 4'h0, 32'h01020304, 8'd1, 1'b0, 1'b0});
      v.push_back('{1'b1, 16'h1004, 4'h5, 32'h11223344, 8'd2, 1'b0, 1'b0});
      v.push_back('{1'b0, 16'h1004, 4'h0, 32'h0,        8'd2, 1'b0, 1'b0});
      v.push_back('{1'b0, 16'h2008, 4'h0, 32'h0,        8'd1, 1'b1, 1'b0});
      v.push_back('{1'b0, 16'h8004, 4'h0, 32'h0,        8'd1, 1'b0, 1'b0});
      foreach (v[i]) begin
         model_xfer(v[i], e);
         apb_xfer(v[i], o);
         checks++;
         if (o !== e) begin
            errors++; $display("FAIL directed[%0d]: got %h expected %h", i, o, e);
         end
         idle(1);
      end
   endtask

   task automatic test_abandon();
      logic seen, reqseen;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0020; busy = 1'b0;
      @(negedge clk); penable = 1'b1; seen = pready;
      @(negedge clk); psel = 1'b0; penable = 1'b0; seen |= pready; reqseen = rf_req;
      @(negedge clk); rf_ack = 1'b1; rf_rdata = $urandom; seen |= pready;
      @(negedge clk); rf_ack = 1'b0; seen |= pready;
      checks++;
      if (rf_req !== 1'b0) begin errors++; $display("FAIL abandon_req_drop: got %b expected 0", rf_req); end
      repeat (4) begin @(negedge clk); seen |= pready; end
      checks++;
      if (reqseen !== 1'b1) begin errors++; $display("FAIL abandon_req: got %b expected 1", reqseen); end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abandon_pready: got %b expected 0", seen); end
      checks++;
      if (err_cnt !== 8'(ref_ecnt)) begin errors++; $display("FAIL abandon_errcnt: got %0d expected %0d", err_cnt, ref_ecnt); end
   endtask

   task automatic test_random();
      vec_t v;
      res_t o, e;
      for (int i = 0; i < 150; i++) begin
         gen(v);
         model_xfer(v, e);
         apb_xfer(v, o);
         checks++;
         if (o !== e) begin
            errors++; $display("FAIL random[%0d] addr=%h: got %h expected %h", i, v.addr, o, e);
         end
         idle($urandom_range(0, 2));
      end
   endtask

   task automatic test_back_to_back();
      vec_t v;
      res_t o, e;
      for (int i = 0; i < 40; i++) begin
         gen(v);
         model_xfer(v, e);
         apb_xfer(v, o);
         checks++;
         if (o !== e) begin
            errors++; $display("FAIL b2b[%0d] addr=%h: got %h expected %h", i, v.addr, o, e);
         end
      end
      idle(1);
   endtask

   task automatic test_err_saturation();
      vec_t v;
      res_t o, e;
      v = '{1'b0, 16'h0001, 4'h0, 32'h0, 8'd1, 1'b0, 1'b0};
      for (int i = 0; i < 260; i++) begin
         model_xfer(v, e);
         apb_xfer(v, o);
         checks++;
         if (o !== e) begin
            errors++; $display("FAIL err_sat[%0d]: got %h expected %h", i, o, e);
         end
      end
      idle(1);
   endtask

   task automatic test_reset_mid();
      vec_t v;
      res_t o, e;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h3000; busy = 1'b0;
      @(negedge clk); penable = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rf_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req: got %b expected 1", rf_req); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({pready, pslverr, rf_req, rf_we, prdata, rf_tgt, rf_addr, rf_be, rf_wdata, err_cnt} !== '0) begin
         errors++; $display("FAIL rst_mid_outputs: pready=%b rf_req=%b err_cnt=%0d rf_addr=%h expected all 0", pready, rf_req, err_cnt, rf_addr);
      end
      rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
      ref_ecnt = 0;
      idle(2);
      v = '{1'b1, 16'h2010, 4'hF, 32'h0BADF00D, 8'd2, 1'b0, 1'b0};
      model_xfer(v, e);
      apb_xfer(v, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid_wr: got %h expected %h", o, e); end
      v = '{1'b0, 16'h2010, 4'h0, 32'h0, 8'd1, 1'b0, 1'b0};
      model_xfer(v, e);
      apb_xfer(v, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid_rd: got %h expected %h", o, e); end
      idle(1);
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; busy = 1'b0;
      pstrb = '0; pwdata = '0; paddr = '0;
      rf_ack = 1'b0; rf_err = 1'b0; rf_rdata = '0;
      checks = 0; errors = 0; ref_ecnt = 0;
      for (int i = 0; i < 4096; i++) begin
         tgt_mem[i] = '0;
         ref_mem[i] = '0;
      end
      test_reset();
      test_directed();
      test_abandon();
      test_random();
      test_back_to_back();
      test_err_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
